// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: two big-endian byte reads per 16-bit instruction, valid/ready to decode.
// Optional handshake counter enabled by defining IMEM_FETCH_COUNT_EN.
module imem_fetch_sequencer #(
    parameter int          MEM_BYTES = 512,
    parameter int          ADDR_W    = 9,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [15:0]       redirect_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [15:0]       ins,
    output logic [15:0]       ins_pc,
    output logic              fault,
    output logic              busy
`ifdef IMEM_FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CAP_LO, HOLD, FAULT} state_e;

    state_e            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       ins_q, ins_d;
    logic [15:0]       ins_pc_q, ins_pc_d;
    logic              ins_valid_q, ins_valid_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       pc_inc;
    logic              launch;
    logic [15:0]       launch_pc;

    // Both bytes of the instruction must sit inside memory; 17 bits so pc overflow is caught.
    function automatic logic in_range(input logic [15:0] p);
        logic [16:0] last_byte;
        last_byte = {p, 1'b0} + 17'd1;
        return last_byte <= 17'(MEM_BYTES - 1);
    endfunction

    assign pc_inc = pc_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            ins_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            ins_valid_q <= ins_valid_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        ins_valid_d = ins_valid_q;
        fault_d     = fault_q;
        launch      = 1'b0;
        launch_pc   = pc_q;
        if (redirect_valid) begin
            // Redirect wins over everything, including a same-cycle handshake.
            pc_d        = redirect_pc;
            ins_valid_d = 1'b0;
            fault_d     = 1'b0;
            state_d     = IDLE;
            launch      = run;
            launch_pc   = redirect_pc;
        end else begin
            case (state_q)
                IDLE: begin
                    launch = run;
                end
                RD_HI: begin
                    state_d = RD_LO;
                end
                RD_LO: begin
                    ins_d[15:8] = mem_rdata;
                    state_d     = CAP_LO;
                end
                CAP_LO: begin
                    ins_d[7:0]  = mem_rdata;
                    ins_pc_d    = pc_q;
                    ins_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (ins_ready) begin
                        ins_valid_d = 1'b0;
                        pc_d        = pc_inc;
                        state_d     = IDLE;
                        launch      = run;
                        launch_pc   = pc_inc;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // Every entry to RD_HI goes through the bounds check.
        if (launch) begin
            if (in_range(launch_pc)) begin
                state_d = RD_HI;
            end else begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_rd_en = !redirect_valid && (state_q == RD_HI || state_q == RD_LO);
        mem_addr  = mem_addr_q;
        if (mem_rd_en) begin
            mem_addr = (state_q == RD_HI) ? {pc_q[ADDR_W-2:0], 1'b0} : {pc_q[ADDR_W-2:0], 1'b1};
        end
        busy = (state_q != IDLE) && (state_q != FAULT);
    end

    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = ins_valid_q;
    assign fault     = fault_q;

`ifdef IMEM_FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (ins_valid_q && ins_ready && !redirect_valid && fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a byte-wide synchronous-read memory model.
module tb_imem_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        mem_rd_en;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic        fault;
    logic        busy;
`ifdef IMEM_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    logic [7:0] mem [0:511];
    int checks = 0;
    int errors = 0;

    imem_fetch_sequencer #(.MEM_BYTES(512), .ADDR_W(9), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
        .fault(fault), .busy(busy)
`ifdef IMEM_FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_valid"}, 32'(ins_valid), 32'h0);
        chk({tag, "_ins"}, 32'(ins), 32'h0);
        chk({tag, "_ins_pc"}, 32'(ins_pc), 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
`ifdef IMEM_FETCH_COUNT_EN
        chk({tag, "_count"}, 32'(fetch_count), 32'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        mem[4] = 8'h11; mem[5] = 8'h22;
        mem[32] = 8'h5A; mem[33] = 8'h6B; mem[34] = 8'h77; mem[35] = 8'h88;
        mem[510] = 8'hE5; mem[511] = 8'hF6;

        tick(); tick();
        chk_reset("reset");

        // Back-to-back fetch of two instructions
        rst_n = 1'b1; run = 1'b1; ins_ready = 1'b1;
        tick();
        chk("rdhi0_en", 32'(mem_rd_en), 32'h1);
        chk("rdhi0_addr", 32'(mem_addr), 32'h0);
        chk("rdhi0_busy", 32'(busy), 32'h1);
        tick();
        chk("rdlo0_en", 32'(mem_rd_en), 32'h1);
        chk("rdlo0_addr", 32'(mem_addr), 32'h1);
        tick();
        chk("cap0_en", 32'(mem_rd_en), 32'h0);
        chk("cap0_addr_hold", 32'(mem_addr), 32'h1);
        chk("cap0_valid", 32'(ins_valid), 32'h0);
        tick();
        chk("hold0_valid", 32'(ins_valid), 32'h1);
        chk("hold0_ins", 32'(ins), 32'hA1B2);
        chk("hold0_pc", 32'(ins_pc), 32'h0);
        tick();
        chk("rdhi1_addr", 32'(mem_addr), 32'h2);
        chk("rdhi1_valid", 32'(ins_valid), 32'h0);
        tick();
        chk("rdlo1_addr", 32'(mem_addr), 32'h3);
        tick();
        tick();
        chk("hold1_ins", 32'(ins), 32'hC3D4);
        chk("hold1_pc", 32'(ins_pc), 32'h1);

        // Backpressure: decode stalls five cycles
        ins_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(ins_valid), 32'h1);
            chk("stall_ins", 32'(ins), 32'hC3D4);
            chk("stall_pc", 32'(ins_pc), 32'h1);
            chk("stall_rd_en", 32'(mem_rd_en), 32'h0);
        end
        ins_ready = 1'b1;
        tick();
        chk("rdhi2_en", 32'(mem_rd_en), 32'h1);
        chk("rdhi2_addr", 32'(mem_addr), 32'h4);

        // Redirect during RD_LO drops the partial word
        tick();
        chk("rdlo2_addr", 32'(mem_addr), 32'h5);
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        #1 chk("redir_rd_en", 32'(mem_rd_en), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1 chk("redir_hi_addr", 32'(mem_addr), 32'd32);
        chk("redir_hi_en", 32'(mem_rd_en), 32'h1);
        tick();
        chk("redir_lo_addr", 32'(mem_addr), 32'd33);
        tick(); tick();
        chk("redir_ins", 32'(ins), 32'h5A6B);
        chk("redir_pc", 32'(ins_pc), 32'h10);
        tick();
        chk("pc11_addr", 32'(mem_addr), 32'd34);
        tick(); tick(); tick();
        chk("pc11_ins", 32'(ins), 32'h7788);
        chk("pc11_pc", 32'(ins_pc), 32'h11);
`ifdef IMEM_FETCH_COUNT_EN
        chk("count3", 32'(fetch_count), 32'd3);
`endif

        // Out-of-range redirect coinciding with a ready handshake
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        #1 chk("oor_rd_en", 32'(mem_rd_en), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1 chk("fault_set", 32'(fault), 32'h1);
        chk("fault_valid", 32'(ins_valid), 32'h0);
        chk("fault_rd_en", 32'(mem_rd_en), 32'h0);
        chk("fault_busy", 32'(busy), 32'h0);
`ifdef IMEM_FETCH_COUNT_EN
        chk("count_redir", 32'(fetch_count), 32'd3);
`endif
        tick(); tick();
        chk("fault_sticky", 32'(fault), 32'h1);
        chk("fault_no_rd", 32'(mem_rd_en), 32'h0);

        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        #1 chk("unfault", 32'(fault), 32'h0);
        chk("unfault_en", 32'(mem_rd_en), 32'h1);
        chk("unfault_addr", 32'(mem_addr), 32'h0);
        chk("unfault_busy", 32'(busy), 32'h1);

        // Reset in CAP_LO
        tick(); tick();
        chk("cap_pre_rst_en", 32'(mem_rd_en), 32'h0);
        chk("cap_pre_rst_valid", 32'(ins_valid), 32'h0);
        rst_n = 1'b0;
        tick();
        chk_reset("midrst");
        rst_n = 1'b1;
        tick();
        chk("restart_en", 32'(mem_rd_en), 32'h1);
        chk("restart_addr", 32'(mem_addr), 32'h0);

        // Last in-range instruction, then pc+1 runs off the end
        redirect_valid = 1'b1; redirect_pc = 16'h00FF;
        tick();
        redirect_valid = 1'b0;
        #1 chk("edge_fault", 32'(fault), 32'h0);
        chk("edge_hi_addr", 32'(mem_addr), 32'h1FE);
        tick();
        chk("edge_lo_addr", 32'(mem_addr), 32'h1FF);
        tick(); tick();
        chk("edge_ins", 32'(ins), 32'hE5F6);
        chk("edge_pc", 32'(ins_pc), 32'hFF);
        tick();
        chk("wrap_fault", 32'(fault), 32'h1);
        chk("wrap_rd_en", 32'(mem_rd_en), 32'h0);

        // Redirect with run low lands in IDLE
        run = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        #1 chk("idle_fault", 32'(fault), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_rd_en", 32'(mem_rd_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
